// File: rtl/cpu_pkg.sv
// Shared definitions for the lab processor sequencer: opcodes, state encoding,
// ALU select codes and instruction field extraction.
package cpu_pkg;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam int OPC_LSB  = 12;
    localparam int RA_LSB   = 8;
    localparam int RB_LSB   = 4;
    localparam int RW_LSB   = 0;
    localparam int LDA_LSB  = 4;
    localparam int STA_LSB  = 0;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_STORE  = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    function automatic logic [3:0] f_opcode(input logic [15:0] ir);
        return ir[OPC_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_ra(input logic [15:0] ir);
        return ir[RA_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_rb(input logic [15:0] ir);
        return ir[RB_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_rw(input logic [15:0] ir);
        return ir[RW_LSB +: 4];
    endfunction

    function automatic logic [7:0] f_ld_addr(input logic [15:0] ir);
        return ir[LDA_LSB +: 8];
    endfunction

    function automatic logic [7:0] f_st_addr(input logic [15:0] ir);
        return ir[STA_LSB +: 8];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: asynchronous clear, increment on enable, wraps modulo 2^PC_W.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit lab processor. All datapath
// controls are registered alongside the state so they change with it.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     IM_data,
    output logic [PC_W-1:0] IM_addr,
    output logic            IM_rd,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic            RF_Ra_rd,
    output logic            RF_Rb_rd,
    output logic [2:0]      Alu_s0,
    output logic [3:0]      state_dbg,
    output logic [PC_W-1:0] pc_dbg,
    output logic [15:0]     ir_dbg
);

    state_t          r_state;
    logic [15:0]     r_ir;
    logic            r_im_rd;
    logic [7:0]      r_d_addr;
    logic            r_d_wr;
    logic            r_rf_s;
    logic [3:0]      r_w_addr;
    logic            r_w_wr;
    logic [3:0]      r_ra_addr;
    logic [3:0]      r_rb_addr;
    logic            r_ra_rd;
    logic            r_rb_rd;
    logic [2:0]      r_alu;
    logic            w_pc_inc;
    logic [PC_W-1:0] w_pc;

    assign w_pc_inc = (r_state == S_FETCH);

    program_counter #(.PC_W(PC_W)) u_pc (
        .Clock (Clock),
        .Reset (Reset),
        .i_inc (w_pc_inc),
        .o_pc  (w_pc)
    );

    // Outputs are loaded with the values belonging to the state being entered,
    // so execute-state controls come from IM_data only through a flop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_INIT;
            r_ir      <= 16'h0000;
            r_im_rd   <= 1'b0;
            r_d_addr  <= 8'h00;
            r_d_wr    <= 1'b0;
            r_rf_s    <= 1'b0;
            r_w_addr  <= 4'h0;
            r_w_wr    <= 1'b0;
            r_ra_addr <= 4'h0;
            r_rb_addr <= 4'h0;
            r_ra_rd   <= 1'b0;
            r_rb_rd   <= 1'b0;
            r_alu     <= ALU_PASS;
        end else begin
            r_im_rd   <= 1'b0;
            r_d_addr  <= 8'h00;
            r_d_wr    <= 1'b0;
            r_rf_s    <= 1'b0;
            r_w_addr  <= 4'h0;
            r_w_wr    <= 1'b0;
            r_ra_addr <= 4'h0;
            r_rb_addr <= 4'h0;
            r_ra_rd   <= 1'b0;
            r_rb_rd   <= 1'b0;
            r_alu     <= ALU_PASS;
            case (r_state)
                S_INIT: begin
                    r_state <= S_FETCH;
                    r_im_rd <= 1'b1;
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir <= IM_data;
                    case (f_opcode(IM_data))
                        OP_NOOP: begin
                            r_state <= S_NOOP;
                        end
                        OP_STORE: begin
                            r_state   <= S_STORE;
                            r_d_addr  <= f_st_addr(IM_data);
                            r_ra_addr <= f_ra(IM_data);
                            r_ra_rd   <= 1'b1;
                            r_d_wr    <= 1'b1;
                        end
                        OP_LOAD: begin
                            r_state  <= S_LOAD_A;
                            r_d_addr <= f_ld_addr(IM_data);
                            r_rf_s   <= 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            r_state   <= (f_opcode(IM_data) == OP_ADD) ? S_ADD : S_SUB;
                            r_alu     <= (f_opcode(IM_data) == OP_ADD) ? ALU_ADD : ALU_SUB;
                            r_ra_addr <= f_ra(IM_data);
                            r_rb_addr <= f_rb(IM_data);
                            r_ra_rd   <= 1'b1;
                            r_rb_rd   <= 1'b1;
                            r_w_addr  <= f_rw(IM_data);
                            r_w_wr    <= 1'b1;
                        end
                        OP_HALT: begin
                            r_state <= S_HALT;
                        end
                        default: begin
                            r_state <= S_NOOP;
                        end
                    endcase
                end
                S_LOAD_A: begin
                    r_state  <= S_LOAD_B;
                    r_d_addr <= f_ld_addr(r_ir);
                    r_rf_s   <= 1'b1;
                    r_w_addr <= f_rw(r_ir);
                    r_w_wr   <= 1'b1;
                end
                S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: begin
                    r_state <= S_FETCH;
                    r_im_rd <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign IM_addr    = w_pc;
    assign IM_rd      = r_im_rd;
    assign D_addr     = r_d_addr;
    assign D_wr       = r_d_wr;
    assign RF_s       = r_rf_s;
    assign RF_W_addr  = r_w_addr;
    assign RF_W_wr    = r_w_wr;
    assign RF_Ra_addr = r_ra_addr;
    assign RF_Rb_addr = r_rb_addr;
    assign RF_Ra_rd   = r_ra_rd;
    assign RF_Rb_rd   = r_rb_rd;
    assign Alu_s0     = r_alu;
    assign state_dbg  = r_state;
    assign pc_dbg     = w_pc;
    assign ir_dbg     = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural synchronous instruction ROM.
module tb_control_unit;

    localparam int PC_W = 7;

    logic            clk = 1'b0;
    logic            Reset;
    logic [15:0]     im_q;
    logic [PC_W-1:0] IM_addr;
    logic            IM_rd;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_wr;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic            RF_Ra_rd;
    logic            RF_Rb_rd;
    logic [2:0]      Alu_s0;
    logic [3:0]      state_dbg;
    logic [PC_W-1:0] pc_dbg;
    logic [15:0]     ir_dbg;

    logic [15:0] rom [0:127];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (IM_rd) im_q <= rom[IM_addr];
    end

    control_unit #(.PC_W(PC_W)) dut (
        .Clock(clk), .Reset(Reset), .IM_data(im_q), .IM_addr(IM_addr), .IM_rd(IM_rd),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_Ra_rd(RF_Ra_rd), .RF_Rb_rd(RF_Rb_rd),
        .Alu_s0(Alu_s0), .state_dbg(state_dbg), .pc_dbg(pc_dbg), .ir_dbg(ir_dbg)
    );

    wire [28:0] all_ctl = {D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Rb_addr,
                           RF_Ra_rd, RF_Rb_rd, Alu_s0, IM_rd};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_fill(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    // Holds reset for two cycles and releases it at a falling edge (INIT cycle).
    task automatic restart();
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
    endtask

    initial begin
        int wr_cnt;
        int dwr_cnt;
        logic any_en;

        Reset = 1'b1;
        rom_fill(16'h0000, 16'h0000, 16'h0000);
        cyc(3);

        // Reset while running, then release
        Reset = 1'b0;
        cyc(5);
        Reset = 1'b1;
        #1;
        check("rst_outputs", {3'b000, all_ctl}, 32'h0);
        check("rst_state", state_dbg, 32'h0);
        check("rst_pc", pc_dbg, 32'h0);
        check("rst_ir", ir_dbg, 32'h0);
        cyc(2);
        Reset = 1'b0;
        check("init_state", state_dbg, 32'h0);
        check("init_imrd", IM_rd, 32'h0);
        cyc(1);
        check("fetch1_imrd", IM_rd, 32'h1);
        check("fetch1_addr", IM_addr, 32'h0);
        check("fetch1_state", state_dbg, 32'h1);

        // LOAD 0x2A -> R3, then HALT
        rom_fill(16'h22A3, 16'h5000, 16'h0000);
        restart();
        cyc(2);
        check("ld_dec_pc", pc_dbg, 32'h1);
        check("ld_dec_ctl", {3'b000, all_ctl}, 32'h0);
        cyc(1);
        check("lda_state", state_dbg, 32'h5);
        check("lda_daddr", D_addr, 32'h2A);
        check("lda_rfs", RF_s, 32'h1);
        check("lda_wwr", RF_W_wr, 32'h0);
        cyc(1);
        check("ldb_state", state_dbg, 32'h6);
        check("ldb_daddr", D_addr, 32'h2A);
        check("ldb_rfs", RF_s, 32'h1);
        check("ldb_wwr", RF_W_wr, 32'h1);
        check("ldb_waddr", RF_W_addr, 32'h3);
        check("ldb_ir", ir_dbg, 32'h22A3);
        cyc(1);
        check("ld_next_fetch", state_dbg, 32'h1);
        check("ld_next_wwr", RF_W_wr, 32'h0);
        check("ld_next_addr", IM_addr, 32'h1);
        cyc(2);
        check("halt_state", state_dbg, 32'h9);
        cyc(5);
        check("halt_hold_state", state_dbg, 32'h9);
        check("halt_hold_pc", pc_dbg, 32'h2);
        check("halt_hold_ir", ir_dbg, 32'h5000);
        check("halt_hold_ctl", {3'b000, all_ctl}, 32'h0);

        // ADD R1,R2->R4 then SUB R1,R2->R5
        rom_fill(16'h3124, 16'h4125, 16'h5000);
        restart();
        wr_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            cyc(1);
            if (RF_W_wr) wr_cnt++;
            if (c == 3) begin
                check("add_state", state_dbg, 32'h7);
                check("add_alu", Alu_s0, 32'h1);
                check("add_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 32'h124);
                check("add_en", {RF_Ra_rd, RF_Rb_rd, RF_W_wr, RF_s, D_wr}, 32'h1C);
            end
            if (c == 4) check("add_then_fetch", state_dbg, 32'h1);
            if (c == 6) begin
                check("sub_state", state_dbg, 32'h8);
                check("sub_alu", Alu_s0, 32'h2);
                check("sub_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 32'h125);
                check("sub_wwr", RF_W_wr, 32'h1);
            end
            if (c == 7) check("sub_then_fetch", state_dbg, 32'h1);
        end
        check("addsub_wr_pulses", wr_cnt, 32'd2);

        // STORE R7 -> 0x80
        rom_fill(16'h1780, 16'h5000, 16'h0000);
        restart();
        dwr_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            if (D_wr) dwr_cnt++;
            if (c == 3) begin
                check("st_state", state_dbg, 32'h4);
                check("st_daddr", D_addr, 32'h80);
                check("st_ra", RF_Ra_addr, 32'h7);
                check("st_en", {D_wr, RF_Ra_rd, RF_Rb_rd, RF_W_wr, RF_s}, 32'h18);
                check("st_alu", Alu_s0, 32'h0);
            end
        end
        check("st_dwr_pulses", dwr_cnt, 32'd1);

        // Illegal opcode followed by NOOPs through address 127 and wrap
        rom_fill(16'hF000, 16'h0000, 16'h0000);
        restart();
        any_en = 1'b0;
        for (int c = 1; c <= 386; c++) begin
            cyc(1);
            any_en = any_en | D_wr | RF_W_wr | RF_Ra_rd | RF_Rb_rd | RF_s;
            if (c == 3) begin
                check("ill_state", state_dbg, 32'h3);
                check("ill_ir", ir_dbg, 32'hF000);
            end
            if (c == 382) begin
                check("wrap_fetch_state", state_dbg, 32'h1);
                check("wrap_fetch_addr", IM_addr, 32'h7F);
            end
            if (c == 383) check("wrap_pc_zero", pc_dbg, 32'h0);
            if (c == 385) begin
                check("wrap_refetch_state", state_dbg, 32'h1);
                check("wrap_refetch_addr", IM_addr, 32'h0);
            end
        end
        check("noop_no_enables", any_en, 32'h0);

        // Reset asserted during LOAD_B drops the write at once
        rom_fill(16'h22A3, 16'h5000, 16'h0000);
        restart();
        cyc(4);
        check("abort_ldb_wwr", RF_W_wr, 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        check("abort_wwr_drop", RF_W_wr, 32'h0);
        check("abort_all_zero", {3'b000, all_ctl}, 32'h0);
        check("abort_pc", pc_dbg, 32'h0);
        cyc(2);
        check("abort_held_wwr", RF_W_wr, 32'h0);
        Reset = 1'b0;
        cyc(1);
        check("restart_fetch_addr", IM_addr, 32'h0);
        check("restart_fetch_rd", IM_rd, 32'h1);
        cyc(2);
        check("restart_lda", state_dbg, 32'h5);
        check("restart_daddr", D_addr, 32'h2A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer for the 16-bit lab processor. It holds the program counter (PC) and instruction register (IR), fetches from a synchronous instruction ROM, and decodes each instruction. It drives every control input of the datapath: data-memory address/write, register-file ports, write-back mux select and ALU select. It sits directly upstream of the datapath; the datapath has no other control source.

## Interface
- `PC_W`, default 7: PC and instruction-ROM address width (128 words).
- `Clock`  in  1: single system clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state immediately.
- `IM_data`  in  16: instruction ROM read data, valid one cycle after `IM_rd`.
- `IM_addr`  out  PC_W: instruction ROM address (always equals PC).
- `IM_rd`  out  1: ROM read strobe.
- `D_addr`  out  8: data-memory address.
- `D_wr`  out  1: data-memory write enable.
- `RF_s`  out  1: write-back mux select; 1 = memory data, 0 = ALU result.
- `RF_W_addr`  out  4: register-file write address.
- `RF_W_wr`  out  1: register-file write enable.
- `RF_Ra_addr` / `RF_Rb_addr`  out  4 each: read addresses.
- `RF_Ra_rd` / `RF_Rb_rd`  out  1 each: read enables.
- `Alu_s0`  out  3: ALU function; 000 = pass/zero, 001 = add, 010 = sub.
- `state_dbg`  out  4, `pc_dbg`  out  PC_W, `ir_dbg`  out  16: debug taps.

## Operation
- Instruction format: `IR[15:12]` is the opcode.
  - NOOP 0000.
  - STORE 0001: Ra = `IR[11:8]`, addr = `IR[7:0]`.
  - LOAD 0010: addr = `IR[11:4]`, Rw = `IR[3:0]`.
  - ADD 0011 and SUB 0100: Ra = `IR[11:8]`, Rb = `IR[7:4]`, Rw = `IR[3:0]`.
  - HALT 0101.
  - Opcodes 0110–1111 are illegal and execute as NOOP.
- States and transitions:
  - INIT: entered on reset; goes to FETCH.
  - FETCH: `IM_rd` = 1; PC <= PC+1 at the edge; goes to DECODE.
  - DECODE: IR <= `IM_data`; the next state is chosen from `IM_data[15:12]` (not IR).
  - Execute states: NOOP, STORE, LOAD_A, LOAD_B, ADD, SUB, HALT.
- Execute-state outputs (every signal not listed is 0):
  - STORE: `D_addr` = `IR[7:0]`, `RF_Ra_addr` = `IR[11:8]`, `RF_Ra_rd` = 1, `D_wr` = 1.
  - LOAD_A: `D_addr` = `IR[11:4]`, `RF_s` = 1.
  - LOAD_B: `D_addr` and `RF_s` held; `RF_W_addr` = `IR[3:0]`, `RF_W_wr` = 1.
  - ADD/SUB: Ra/Rb addresses and both read enables asserted; `Alu_s0` = 001 or 010; `RF_s` = 0; `RF_W_wr` = 1.
  - NOOP, STORE, LOAD_B, ADD and SUB return to FETCH. LOAD_A goes to LOAD_B.
  - HALT: self-loop; only `Reset` exits it. PC and IR stay frozen.
- Outputs are Moore: a function of the state and IR registers only. `IM_data` never reaches the datapath outputs combinationally.
- PC arithmetic is modulo 2^PC_W: 127 wraps to 0 with no flag.

## Timing
- Reset values: state = INIT, PC = 0, IR = 0, and every output 0, including all enables and `IM_rd`.
- Per-instruction cycle counts: NOOP, STORE, ADD and SUB take 3 (FETCH, DECODE, execute); LOAD takes 4.
- The first FETCH occurs in the 2nd cycle after `Reset` deasserts (INIT lasts one cycle).
- LOAD uses 2 cycles because data memory is synchronous: its read data is valid in LOAD_B, when the register file captures it.
- `Reset` mid-instruction aborts it at once: no further `D_wr` or `RF_W_wr` may assert, and a write that was in flight is dropped if `Reset` is asserted before its clock edge.
- Write enables assert for exactly one cycle per instruction.

## Structure
- Shared package `cpu_pkg`: opcode constants, state encoding (4-bit enum), `Alu_s0` codes, instruction field slice positions.
- Sub-module `program_counter`: asynchronous clear, increment enable, PC_W-bit wrap. The FSM and IR stay in `control_unit`.

## Test plan
- Reset while running, then release → all outputs 0; `IM_addr` = 0 in the first FETCH; `IM_rd` asserted in cycle 2.
- ROM holds LOAD 0x2A→R3 (0x22A3), then HALT → `D_addr` = 0x2A with `RF_s` = 1 for 2 cycles; `RF_W_wr` = 1 and `RF_W_addr` = 3 in LOAD_B only; then HALT holds with PC = 2.
- ADD R1,R2→R4 (0x3124), then SUB R1,R2→R5 (0x4125) → `Alu_s0` = 001, then 010; `RF_W_wr` pulses once each; 3 cycles per instruction.
- STORE R7→0x80 (0x1780) → exactly one `D_wr` cycle with `D_addr` = 0x80, `RF_Ra_addr` = 7, `RF_W_wr` = 0.
- Illegal opcode 0xF000, then NOOP-filled ROM to address 127 → executes as NOOP with no enables; PC wraps 127→0 and fetching continues.
- `Reset` asserted during LOAD_B → `RF_W_wr` drops at once (asynchronously); after release, execution restarts at PC = 0.
